// File: rtl/maq_h.sv
// Hour stage of the clock chain: 0..23 counter, BCD digits, day carry, manual set.
// Define MAQH_12H_EN for a 12-hour display with PM flag.
module maq_h #(
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic       maqh_clock,
  input  logic       maqh_reset,
  input  logic       inc_minuto,
  input  logic       inc_hora,
  input  logic       set_mode,
  input  logic       set_btn,
  output logic [3:0] maqh_lsd,
  output logic [1:0] maqh_msd,
  output logic       maqh_inc_dia,
  output logic       maqh_pm
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } st_t;

  st_t           st_q, st_d;
  logic [4:0]    hour_q, hour_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_q, btn_d;
  logic          tick;
  logic          man_inc;
  logic          rise;
  logic [4:0]    disp;

  always_ff @(posedge maqh_clock or posedge maqh_reset) begin
    if (maqh_reset) begin
      st_q   <= IDLE;
      hour_q <= 5'd0;
      cnt_q  <= '0;
      btn_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      hour_q <= hour_d;
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
    end
  end

  assign rise = set_btn & ~btn_q;
  assign tick = ~set_mode & inc_minuto & inc_hora;

  // Leaving HOLD/REPEAT never increments on that edge.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    man_inc = 1'b0;
    btn_d   = set_btn;
    unique case (st_q)
      IDLE: begin
        if (rise && set_mode) begin
          man_inc = 1'b1;
          cnt_d   = '0;
          st_d    = HOLD;
        end
      end
      HOLD: begin
        if (!set_btn || !set_mode) begin
          cnt_d = '0;
          st_d  = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          man_inc = 1'b1;
          cnt_d   = '0;
          st_d    = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!set_btn || !set_mode) begin
          cnt_d = '0;
          st_d  = IDLE;
        end else if (cnt_q == REP_LAST) begin
          man_inc = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        st_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    hour_d = hour_q;
    if (tick || man_inc) begin
      hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end
  end

  assign maqh_inc_dia = (hour_q == 5'd23) & inc_hora & ~set_mode;

  always_comb begin
    disp    = hour_q;
    maqh_pm = 1'b0;
`ifdef MAQH_12H_EN
    if (hour_q >= 5'd12) begin
      disp    = hour_q - 5'd12;
      maqh_pm = 1'b1;
    end
    if (disp == 5'd0) begin
      disp = 5'd12;
    end
`endif
    if (disp >= 5'd20) begin
      maqh_msd = 2'd2;
      maqh_lsd = 4'(disp - 5'd20);
    end else if (disp >= 5'd10) begin
      maqh_msd = 2'd1;
      maqh_lsd = 4'(disp - 5'd10);
    end else begin
      maqh_msd = 2'd0;
      maqh_lsd = disp[3:0];
    end
  end

endmodule

// File: tb/tb_maq_h.sv
// Scoreboard bench for maq_h: day count, tick qualification,
// set priority, press/hold auto-repeat and asynchronous reset.
module tb_maq_h;

  logic       clk;
  logic       rst;
  logic       inc_minuto;
  logic       inc_hora;
  logic       set_mode;
  logic       set_btn;
  logic [3:0] lsd;
  logic [1:0] msd;
  logic       inc_dia;
  logic       pm;

  int n_chk;
  int n_pass;

  typedef struct {
    string tag;
    int    hour;
    int    dia;
  } exp_t;

  exp_t sb_q[$];

  maq_h #(
    .HOLD_CYCLES  (500),
    .REPEAT_CYCLES(100)
  ) dut (
    .maqh_clock  (clk),
    .maqh_reset  (rst),
    .inc_minuto  (inc_minuto),
    .inc_hora    (inc_hora),
    .set_mode    (set_mode),
    .set_btn     (set_btn),
    .maqh_lsd    (lsd),
    .maqh_msd    (msd),
    .maqh_inc_dia(inc_dia),
    .maqh_pm     (pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int disp_of(input int h);
`ifdef MAQH_12H_EN
    int d;
    d = h % 12;
    if (d == 0) d = 12;
    return d;
`else
    return h;
`endif
  endfunction

  function automatic int pm_of(input int h);
`ifdef MAQH_12H_EN
    return (h >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic chk_out(input string tag, input int h, input int dia);
    chk({tag, ".lsd"}, int'(lsd), disp_of(h) % 10);
    chk({tag, ".msd"}, int'(msd), disp_of(h) / 10);
    chk({tag, ".pm"},  int'(pm),  pm_of(h));
    chk({tag, ".dia"}, int'(inc_dia), dia);
  endtask

  // Drive one cycle of inputs, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic im, input logic ih,
                      input logic sm, input logic sbt, input int exp_h);
    exp_t e;
    exp_t o;
    @(negedge clk);
    inc_minuto = im;
    inc_hora   = ih;
    set_mode   = sm;
    set_btn    = sbt;
    e.tag  = tag;
    e.hour = exp_h;
    e.dia  = (exp_h == 23 && ih && !sm) ? 1 : 0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk_out(o.tag, o.hour, o.dia);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("reset", 0, 0);
    @(negedge clk);
    inc_minuto = 1'b0;
    inc_hora   = 1'b0;
    set_mode   = 1'b0;
    set_btn    = 1'b0;
    rst        = 1'b0;
  endtask

  initial begin
    int h;
    n_chk      = 0;
    n_pass     = 0;
    rst        = 1'b1;
    inc_minuto = 1'b0;
    inc_hora   = 1'b0;
    set_mode   = 1'b0;
    set_btn    = 1'b0;
    #1;
    chk_out("por", 0, 0);
    do_reset();

    for (int i = 1; i <= 24; i++) step("day", 1, 1, 0, 0, i % 24);

    for (int i = 1; i <= 5; i++) step("to5", 1, 1, 0, 0, i);
    for (int i = 0; i < 10; i++) step("qual_h", 0, 1, 0, 0, 5);
    for (int i = 0; i < 10; i++) step("qual_m", 1, 0, 0, 0, 5);

    for (int i = 6; i <= 23; i++) step("to23", 1, 1, 0, 0, i);
    step("prio", 1, 1, 1, 0, 23);
    step("held0", 0, 0, 0, 1, 23);
    for (int i = 0; i < 5; i++) step("held1", 0, 0, 1, 1, 23);
    step("rel", 0, 0, 1, 0, 23);
    step("repress", 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("rel2", 0, 0, 1, 0, 0);

    step("tap", 0, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step("tap_rel", 0, 0, 1, 0, 1);

    do_reset();
    h = 0;
    for (int c = 0; c < 1000; c++) begin
      if (c == 0 || (c >= 500 && (c - 500) % 100 == 0)) h++;
      step("hold", 0, 0, 1, 1, h);
    end
    step("hold_rel", 0, 0, 1, 0, 6);

    do_reset();
    h = 0;
    for (int c = 0; c < 550; c++) begin
      if (c == 0 || c == 500) h++;
      step("hold2", 0, 0, 1, 1, h);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 0, 0);
    @(negedge clk);
    set_btn = 1'b0;
    rst     = 1'b0;
    for (int i = 0; i < 100; i++) step("post_rst", 0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
